// File: rtl/bus_config_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_config_sequencer_pkg
//  Description : Shared types for the front-panel bus configuration sequencer:
//                slave selector, operation kind and the sequencer state set.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_config_sequencer_pkg;

    typedef enum logic [1:0] {
        NO_SLAVE = 2'd0,
        SLAVE_1  = 2'd1,
        SLAVE_2  = 2'd2,
        SLAVE_3  = 2'd3
    } slave_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } operation_t;

    // Encoding is exported on state_dbg, so the order is part of the interface.
    typedef enum logic [3:0] {
        ST_SLAVE_SEL = 4'd0,
        ST_RW_SEL    = 4'd1,
        ST_EXTW_SEL  = 4'd2,
        ST_EXT_WR0   = 4'd3,
        ST_EXT_WR1   = 4'd4,
        ST_START0    = 4'd5,
        ST_START1    = 4'd6,
        ST_END0      = 4'd7,
        ST_END1      = 4'd8,
        ST_CFG       = 4'd9,
        ST_READY     = 4'd10,
        ST_COMM      = 4'd11,
        ST_DONE      = 4'd12
    } seq_state_t;

    // A master takes part in a transfer only when it has a slave assigned.
    function automatic logic slave_active(input logic [1:0] sel);
        return slave_t'(sel) != NO_SLAVE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_config_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_config_sequencer_if
//  Description : Configuration / launch / read-back signals between the
//                front-panel sequencer (master side) and the two bus masters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_config_sequencer_if #(
    parameter int DATA_WIDTH        = 16,
    parameter int MASTER_ADDR_WIDTH = 12,
    parameter int WR_ADDR_WIDTH     = 4
);
    logic [3:0]                     cfg_slave;
    logic [1:0]                     cfg_rw;
    logic [2*MASTER_ADDR_WIDTH-1:0] cfg_start_addr;
    logic [2*MASTER_ADDR_WIDTH-1:0] cfg_end_addr;
    logic                           cfg_valid;
    logic [1:0]                     cfg_ack;
    logic                           ext_wr_en;
    logic                           ext_wr_master;
    logic [WR_ADDR_WIDTH-1:0]       ext_wr_addr;
    logic [DATA_WIDTH-1:0]          ext_wr_data;
    logic [1:0]                     com_start;
    logic [1:0]                     com_done;
    logic                           rd_req;
    logic [MASTER_ADDR_WIDTH-1:0]   rd_addr;

    modport master (
        output cfg_slave, cfg_rw, cfg_start_addr, cfg_end_addr, cfg_valid,
        output ext_wr_en, ext_wr_master, ext_wr_addr, ext_wr_data,
        output com_start, rd_req, rd_addr,
        input  cfg_ack, com_done
    );

    modport slave (
        input  cfg_slave, cfg_rw, cfg_start_addr, cfg_end_addr, cfg_valid,
        input  ext_wr_en, ext_wr_master, ext_wr_addr, ext_wr_data,
        input  com_start, rd_req, rd_addr,
        output cfg_ack, com_done
    );
endinterface
`default_nettype wire

// File: rtl/bus_config_sequencer_key_press_detect.sv
`default_nettype none
// ============================================================================
//  Module      : bus_config_sequencer_key_press_detect
//  Description : Two-flop synchronizer for an active-low push button plus a
//                falling-edge detector: one press_o pulse per press, however
//                long the key is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_config_sequencer_key_press_detect (
    input  wire  clk,
    input  wire  rstN,
    input  wire  key_n_i,
    output logic press_o
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Sync chain and edge history reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = prev_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/bus_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_config_sequencer
//  Description : Front-panel sequencer for the two-master serial bus system.
//                Collects slave/RW/external-write/address configuration from
//                KEY/SW, hands it to the masters, launches them with a
//                staggered start and serves read-back address requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_config_sequencer
    import bus_config_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH             = 16,
    parameter int MASTER_ADDR_WIDTH      = 12,
    parameter int MAX_MASTER_WRITE_DEPTH = 16,
    parameter int FIRST_START_MASTER     = 0,
    parameter int COM_START_DELAY        = 0
) (
    input  wire         clk,
    input  wire         rstN,
    input  wire         jump_stateN,
    input  wire         jump_next_addr,
    input  wire  [17:0] SW,
    output logic        communication_ready,
    output logic        communication_done,
    output logic [3:0]  state_dbg,
    bus_config_sequencer_if.master bus
);
    localparam int WAW   = $clog2(MAX_MASTER_WRITE_DEPTH);
    localparam int DLY_W = (COM_START_DELAY > 0) ? $clog2(COM_START_DELAY + 1) : 1;
    localparam logic [WAW-1:0] WR_LAST  = WAW'(MAX_MASTER_WRITE_DEPTH - 1);
    localparam logic           C_FIRST  = (FIRST_START_MASTER != 0);
    localparam logic           C_SECOND = ~C_FIRST;

    logic                         w_jump;
    logic                         w_next;
    logic [1:0]                   w_active;
    logic                         w_all_done;
    logic                         w_unused_sw;

    seq_state_t                   state_q;
    logic [3:0]                   cfg_slave_q;
    logic [1:0]                   cfg_rw_q;
    logic [1:0]                   extw_q;
    logic [MASTER_ADDR_WIDTH-1:0] start0_q, start1_q, end0_q, end1_q;
    logic                         cfg_valid_q;
    logic                         ext_wr_en_q;
    logic                         ext_wr_master_q;
    logic [WAW-1:0]               ext_wr_addr_q;
    logic [WAW-1:0]               wr_ptr_q;
    logic [DATA_WIDTH-1:0]        ext_wr_data_q;
    logic [1:0]                   com_start_q;
    logic [DLY_W-1:0]             dly_cnt_q;
    logic                         dly_pend_q;
    logic                         rd_req_q;
    logic [MASTER_ADDR_WIDTH-1:0] rd_addr_q;
    logic                         ready_q;
    logic                         done_q;

    bus_config_sequencer_key_press_detect u_key_jump (
        .clk     (clk),
        .rstN    (rstN),
        .key_n_i (jump_stateN),
        .press_o (w_jump)
    );

    bus_config_sequencer_key_press_detect u_key_next (
        .clk     (clk),
        .rstN    (rstN),
        .key_n_i (jump_next_addr),
        .press_o (w_next)
    );

    assign w_active    = {slave_active(cfg_slave_q[3:2]), slave_active(cfg_slave_q[1:0])};
    // Inactive masters count as finished; a still-pending delayed start blocks completion.
    assign w_all_done  = ~dly_pend_q & (&(bus.com_done | ~w_active));
    assign w_unused_sw = ^SW[17:DATA_WIDTH];

    // Sequencer FSM: captures panel settings, issues strobes and holds all registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q         <= ST_SLAVE_SEL;
            cfg_slave_q     <= '0;
            cfg_rw_q        <= '0;
            extw_q          <= '0;
            start0_q        <= '0;
            start1_q        <= '0;
            end0_q          <= '0;
            end1_q          <= '0;
            cfg_valid_q     <= 1'b0;
            ext_wr_en_q     <= 1'b0;
            ext_wr_master_q <= 1'b0;
            ext_wr_addr_q   <= '0;
            wr_ptr_q        <= '0;
            ext_wr_data_q   <= '0;
            com_start_q     <= '0;
            dly_cnt_q       <= '0;
            dly_pend_q      <= 1'b0;
            rd_req_q        <= 1'b0;
            rd_addr_q       <= '0;
            ready_q         <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            cfg_valid_q <= 1'b0;
            ext_wr_en_q <= 1'b0;
            com_start_q <= '0;
            rd_req_q    <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_SLAVE_SEL: if (w_jump) begin
                    cfg_slave_q <= SW[3:0];
                    state_q     <= ST_RW_SEL;
                end
                ST_RW_SEL: if (w_jump) begin
                    cfg_rw_q <= SW[1:0];
                    state_q  <= ST_EXTW_SEL;
                end
                ST_EXTW_SEL: if (w_jump) begin
                    extw_q <= SW[1:0];
                    if (SW[0])      state_q <= ST_EXT_WR0;
                    else if (SW[1]) state_q <= ST_EXT_WR1;
                    else            state_q <= ST_START0;
                end
                ST_EXT_WR0, ST_EXT_WR1: begin
                    // A jump always carries the final write, so a simultaneous next press adds nothing.
                    if (w_jump || w_next) begin
                        ext_wr_en_q     <= 1'b1;
                        ext_wr_master_q <= (state_q == ST_EXT_WR1);
                        ext_wr_addr_q   <= wr_ptr_q;
                        ext_wr_data_q   <= SW[DATA_WIDTH-1:0];
                    end
                    if (w_jump) begin
                        wr_ptr_q <= '0;
                        state_q  <= (state_q == ST_EXT_WR0 && extw_q[1]) ? ST_EXT_WR1 : ST_START0;
                    end else if (w_next && wr_ptr_q != WR_LAST) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                end
                ST_START0: if (w_jump) begin
                    start0_q <= SW[MASTER_ADDR_WIDTH-1:0];
                    state_q  <= ST_START1;
                end
                ST_START1: if (w_jump) begin
                    start1_q <= SW[MASTER_ADDR_WIDTH-1:0];
                    state_q  <= ST_END0;
                end
                ST_END0: if (w_jump) begin
                    end0_q  <= SW[MASTER_ADDR_WIDTH-1:0];
                    state_q <= ST_END1;
                end
                ST_END1: if (w_jump) begin
                    end1_q      <= SW[MASTER_ADDR_WIDTH-1:0];
                    cfg_valid_q <= 1'b1;
                    state_q     <= ST_CFG;
                end
                ST_CFG: if (&bus.cfg_ack) begin
                    ready_q <= 1'b1;
                    state_q <= ST_READY;
                end
                ST_READY: begin
                    if (w_jump) begin
                        state_q              <= ST_COMM;
                        com_start_q[C_FIRST] <= w_active[C_FIRST];
                        if (COM_START_DELAY == 0) begin
                            com_start_q[C_SECOND] <= w_active[C_SECOND];
                        end else begin
                            dly_pend_q <= w_active[C_SECOND];
                            dly_cnt_q  <= DLY_W'(COM_START_DELAY);
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_COMM: begin
                    if (dly_pend_q) begin
                        if (dly_cnt_q == DLY_W'(1)) begin
                            com_start_q[C_SECOND] <= 1'b1;
                            dly_pend_q            <= 1'b0;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - 1'b1;
                        end
                    end else if (w_all_done) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_next) begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= SW[MASTER_ADDR_WIDTH-1:0];
                    end
                    if (w_jump) state_q <= ST_SLAVE_SEL;
                    else        done_q  <= 1'b1;
                end
                default: state_q <= ST_SLAVE_SEL;
            endcase
        end
    end

    assign bus.cfg_slave        = cfg_slave_q;
    assign bus.cfg_rw           = cfg_rw_q;
    assign bus.cfg_start_addr   = {start1_q, start0_q};
    assign bus.cfg_end_addr     = {end1_q, end0_q};
    assign bus.cfg_valid        = cfg_valid_q;
    assign bus.ext_wr_en        = ext_wr_en_q;
    assign bus.ext_wr_master    = ext_wr_master_q;
    assign bus.ext_wr_addr      = ext_wr_addr_q;
    assign bus.ext_wr_data      = ext_wr_data_q;
    assign bus.com_start        = com_start_q;
    assign bus.rd_req           = rd_req_q;
    assign bus.rd_addr          = rd_addr_q;
    assign communication_ready  = ready_q;
    assign communication_done   = done_q;
    assign state_dbg            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_config_sequencer
//  Description : Self-checking bench for bus_config_sequencer. A user-level
//                model of the panel session queues the strobes the sequencer
//                must emit (with their cycle); a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_config_sequencer;
    localparam int TB_FIRST = 1;
    localparam int TB_DELAY = 10;
    localparam int TB_DEPTH = 16;

    // Panel states in the documented order.
    localparam int S_SLAVE_SEL = 0, S_RW_SEL = 1, S_EXTW_SEL = 2, S_EXT_WR0 = 3,
                   S_EXT_WR1 = 4, S_START0 = 5, S_CFG = 9, S_READY = 10,
                   S_COMM = 11, S_DONE = 12;
    localparam int K_CFG = 0, K_WR = 1, K_START = 2, K_RD = 3;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        rstN;
    logic        jump_stateN;
    logic        jump_next_addr;
    logic [17:0] SW;
    logic        communication_ready;
    logic        communication_done;
    logic [3:0]  state_dbg;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];

    bus_config_sequencer_if #(.DATA_WIDTH(16), .MASTER_ADDR_WIDTH(12), .WR_ADDR_WIDTH(4)) bus ();

    bus_config_sequencer #(
        .DATA_WIDTH             (16),
        .MASTER_ADDR_WIDTH      (12),
        .MAX_MASTER_WRITE_DEPTH (TB_DEPTH),
        .FIRST_START_MASTER     (TB_FIRST),
        .COM_START_DELAY        (TB_DELAY)
    ) dut (
        .clk                 (clk),
        .rstN                (rstN),
        .jump_stateN         (jump_stateN),
        .jump_next_addr      (jump_next_addr),
        .SW                  (SW),
        .communication_ready (communication_ready),
        .communication_done  (communication_done),
        .state_dbg           (state_dbg),
        .bus                 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_state(input string name, input int exp);
        chk(name, 64'(state_dbg), 64'(exp));
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input int at);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h c=%0h cyc=%0d, none required",
                     kind, a, b, c, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b || e.c !== c || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind=%0d a=%0h b=%0h c=%0h cyc=%0d expected kind=%0d a=%0h b=%0h c=%0h cyc=%0d",
                         kind, a, b, c, cyc, e.kind, e.a, e.b, e.c, e.cyc);
            end
        end
    endtask

    // Monitor: every strobe the sequencer presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstN) begin
            if (bus.cfg_valid)
                observe(K_CFG, 32'({bus.cfg_slave, bus.cfg_rw}), 32'(bus.cfg_start_addr), 32'(bus.cfg_end_addr));
            if (bus.ext_wr_en)
                observe(K_WR, 32'(bus.ext_wr_master), 32'(bus.ext_wr_addr), 32'(bus.ext_wr_data));
            if (bus.com_start != 2'b00)
                observe(K_START, 32'(bus.com_start), 32'd0, 32'd0);
            if (bus.rd_req)
                observe(K_RD, 32'(bus.rd_addr), 32'd0, 32'd0);
        end
    end

    // A press is acted on at the third clock edge after the key falls.
    task automatic key_down(input logic j, input logic n, output int act);
        @(posedge clk); #1;
        if (j) jump_stateN = 1'b0;
        if (n) jump_next_addr = 1'b0;
        act = cyc + 3;
    endtask

    task automatic key_up();
        repeat (2) @(posedge clk);
        #1;
        jump_stateN    = 1'b1;
        jump_next_addr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic jump_with(input logic [17:0] sw);
        int act;
        SW = sw;
        key_down(1'b1, 1'b0, act);
        key_up();
    endtask

    function automatic logic [97:0] all_outputs();
        return {bus.cfg_slave, bus.cfg_rw, bus.cfg_start_addr, bus.cfg_end_addr, bus.cfg_valid,
                bus.ext_wr_en, bus.ext_wr_master, bus.ext_wr_addr, bus.ext_wr_data, bus.com_start,
                bus.rd_req, bus.rd_addr, communication_ready, communication_done, state_dbg};
    endfunction

    // One full panel session from SLAVE_SEL back to SLAVE_SEL.
    task automatic session(input logic [3:0] slave, input logic [1:0] rw, input logic [1:0] extw,
                           input int nw0, input int nw1, input logic [3:0][11:0] ad,
                           input bit hold, input int n_rd, input logic [11:0] rd_sw0);
        int          act;
        int          cnt;
        int          jcyc;
        int          tstart[2];
        int          tdone[2];
        int          dcyc;
        logic [3:0]  prev;
        logic [1:0]  act_m;
        logic [17:0] sw;
        bus.cfg_ack  = 2'b00;
        bus.com_done = 2'b00;
        act_m = {slave[3:2] != 2'b00, slave[1:0] != 2'b00};

        sw = 18'($urandom); sw[3:0] = slave;
        if (hold) begin
            SW = sw;
            key_down(1'b1, 1'b0, act);
            cnt  = 0;
            prev = state_dbg;
            repeat (200) begin
                @(negedge clk);
                if (state_dbg != prev) cnt++;
                prev = state_dbg;
            end
            key_up();
            chk("hold_single_advance", 64'(cnt), 64'd1);
        end else begin
            jump_with(sw);
        end
        chk_state("slave_sel_to_rw", S_RW_SEL);
        sw = 18'($urandom); sw[1:0] = rw;
        jump_with(sw);
        chk_state("rw_to_extw", S_EXTW_SEL);
        sw = 18'($urandom); sw[1:0] = extw;
        jump_with(sw);
        chk_state("extw_next", extw[0] ? S_EXT_WR0 : (extw[1] ? S_EXT_WR1 : S_START0));

        for (int m = 0; m < 2; m++) begin
            if (extw[m]) begin
                int n;
                n = (m == 0) ? nw0 : nw1;
                for (int i = 0; i < n; i++) begin
                    SW = 18'($urandom);
                    key_down(1'b0, 1'b1, act);
                    push(K_WR, 32'(m), 32'(imin(i, TB_DEPTH - 1)), 32'(SW[15:0]), act);
                    key_up();
                end
                SW = 18'($urandom);
                key_down(1'b1, 1'($urandom_range(0, 1)), act);
                push(K_WR, 32'(m), 32'(imin(n, TB_DEPTH - 1)), 32'(SW[15:0]), act);
                key_up();
                chk_state("ext_wr_exit", (m == 0 && extw[1]) ? S_EXT_WR1 : S_START0);
            end
        end

        for (int k = 0; k < 4; k++) begin
            SW = 18'($urandom); SW[11:0] = ad[k];
            key_down(1'b1, 1'b0, act);
            if (k == 3) push(K_CFG, 32'({slave, rw}), 32'({ad[1], ad[0]}), 32'({ad[3], ad[2]}), act);
            key_up();
        end
        chk_state("addr_to_cfg", S_CFG);

        // Only one master acknowledges at first: the sequencer must keep waiting.
        bus.cfg_ack = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        @(negedge clk);
        chk_state("cfg_wait_ack", S_CFG);
        chk("ready_led_in_cfg", 64'(communication_ready), 64'd0);
        @(posedge clk); #1;
        bus.cfg_ack = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        chk_state("cfg_to_ready", S_READY);
        chk("ready_led", 64'(communication_ready), 64'd1);

        // A next_addr press in READY is ignored.
        SW = 18'($urandom);
        key_down(1'b0, 1'b1, act);
        key_up();
        chk_state("ready_ignores_next", S_READY);

        SW = 18'($urandom);
        key_down(1'b1, 1'b0, act);
        jcyc = act;
        tstart[TB_FIRST]     = jcyc;
        tstart[1 - TB_FIRST] = jcyc + TB_DELAY;
        if (TB_DELAY == 0) begin
            if (act_m != 2'b00) push(K_START, 32'(act_m), 0, 0, jcyc);
        end else begin
            if (act_m[TB_FIRST])     push(K_START, 32'(2'b01 << TB_FIRST), 0, 0, jcyc);
            if (act_m[1 - TB_FIRST]) push(K_START, 32'(2'b01 << (1 - TB_FIRST)), 0, 0, jcyc + TB_DELAY);
        end
        key_up();
        chk("ready_led_off", 64'(communication_ready), 64'd0);

        dcyc = jcyc + 1;
        for (int m = 0; m < 2; m++) begin
            tdone[m] = tstart[m] + $urandom_range(1, 4);
            if (act_m[m] && tdone[m] + 1 > dcyc) dcyc = tdone[m] + 1;
        end
        for (int g = 0; g < 100; g++) begin
            for (int m = 0; m < 2; m++)
                if (act_m[m] && tdone[m] == cyc) bus.com_done[m] = 1'b1;
            @(negedge clk);
            if (cyc == dcyc - 1) chk_state("comm_waits_done", S_COMM);
            if (cyc >= dcyc) begin
                chk_state("comm_to_done", S_DONE);
                chk("done_led", 64'(communication_done), 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        for (int r = 0; r < n_rd; r++) begin
            SW = 18'($urandom);
            if (r == 0) SW[11:0] = rd_sw0;
            key_down(1'b0, 1'b1, act);
            push(K_RD, 32'(SW[11:0]), 0, 0, act);
            key_up();
        end
        jump_with(18'($urandom));
        chk_state("done_to_slave_sel", S_SLAVE_SEL);
        chk("done_led_off", 64'(communication_done), 64'd0);
        bus.cfg_ack  = 2'b00;
        bus.com_done = 2'b00;
    endtask

    // Asynchronous reset while writing external data into master 0.
    task automatic reset_test();
        int act;
        jump_with({14'($urandom), 4'b0011});
        jump_with({16'($urandom), 2'b11});
        jump_with({16'($urandom), 2'b01});
        chk_state("rst_setup_ext_wr0", S_EXT_WR0);
        for (int i = 0; i < 4; i++) begin
            SW = 18'($urandom);
            key_down(1'b0, 1'b1, act);
            push(K_WR, 32'd0, 32'(i), 32'(SW[15:0]), act);
            key_up();
        end
        chk("rst_pre_wr_addr", 64'(bus.ext_wr_addr), 64'd3);
        @(posedge clk); #3;
        rstN = 1'b0;
        #1;
        chk("rst_outputs_zero", 64'(|all_outputs()), 64'd0);
        chk_state("rst_state", S_SLAVE_SEL);
        chk("rst_wr_addr", 64'(bus.ext_wr_addr), 64'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rstN           = 1'b0;
        jump_stateN    = 1'b1;
        jump_next_addr = 1'b1;
        SW             = '0;
        bus.cfg_ack    = 2'b00;
        bus.com_done   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("por_outputs_zero", 64'(|all_outputs()), 64'd0);
        chk_state("por_state", S_SLAVE_SEL);
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        reset_test();
        session(4'b0001, 2'b10, 2'b11, 0, 0, {12'd1, 12'd1, 12'd0, 12'd0}, 1'b0, 1, 12'($urandom));
        session(4'b1110, 2'b01, 2'b10, 2, 3, 48'($urandom) << 16 | 48'($urandom), 1'b1, 0, 12'd0);
        session(4'b1010, 2'b11, 2'b01, TB_DEPTH + 3, 0, {$urandom, $urandom}, 1'b0, 2, 12'($urandom));
        session(4'b0110, 2'b00, 2'b00, 0, 0, {$urandom, $urandom}, 1'b0, 1, 12'($urandom));
        session(4'b0000, 2'b10, 2'b00, 0, 0, {$urandom, $urandom}, 1'b0, 1, 12'd9);
        for (int s = 0; s < 4; s++) begin
            session(4'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 18), $urandom_range(0, 18),
                    {$urandom, $urandom}, 1'b0, $urandom_range(0, 3), 12'($urandom));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
